// File: rtl/button_conditioner.sv
// button_conditioner: three raw pushbuttons -> synchronized, debounced,
// one-cycle action strobes for the pet FSM.
//   - 2-flop synchronizer and independent debounce counter per channel
//   - b_pulse / c_pulse: one strobe in the cycle after the debounced press
//   - any_pressed: OR of the debounced levels, registered
//   - Optional macro BTN_LONGPRESS_EN: channel A becomes a press/long-press
//     FSM (IDLE, DOWN, LONG). A short press strobes a_pulse on release. A
//     hold of LONG_CYC cycles toggles test instead. Without the macro, a_pulse
//     behaves like b_pulse and test is tied to 0.
// Reset rst is asynchronous active-low. Its release is resynchronized so that
// nothing changes earlier than two clocks after rst rises.
module button_conditioner #(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int LONG_CYC     = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_a,
    input  logic btn_b,
    input  logic btn_c,
    output logic a_pulse,
    output logic b_pulse,
    output logic c_pulse,
    output logic test,
    output logic any_pressed
);
    localparam int               DEB_W    = $clog2(DEBOUNCE_CYC + 1);
    // The level flips on the sample that would take the counter to DEBOUNCE_CYC
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    logic [1:0] rst_sync_reg;
    logic       rst_n;
    logic [2:0] btn_raw;
    logic [2:0] db_next_vec;
    logic [2:0] pulse_vec;
    logic       any_pressed_reg;

`ifdef BTN_LONGPRESS_EN
    localparam int                LONG_W   = $clog2(LONG_CYC + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC);

    typedef enum logic [1:0] {
        IDLE,
        DOWN,
        LONG
    } a_state_t;

    a_state_t          a_state_reg;
    logic [LONG_W-1:0] hold_reg;
    logic [LONG_W-1:0] hold_inc;
    logic              a_db;
    logic              a_db_next;
    logic              a_pulse_reg;
    logic              test_reg;
`endif

    assign btn_raw = {btn_c, btn_b, btn_a};

    // Reset synchronizer: assert at once, release two clocks after rst rises
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            logic             db_reg;
            logic             db_next;
            logic [DEB_W-1:0] cnt_reg;
            logic [DEB_W-1:0] cnt_next;

            // Two-flop synchronizer for the raw button
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Count consecutive samples that disagree with the debounced level
            always_comb begin
                db_next  = db_reg;
                cnt_next = '0;
                if (sync2_reg != db_reg) begin
                    if (cnt_reg == DEB_LAST) begin
                        db_next = ~db_reg;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            // Debounce counter and accepted level
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    db_reg  <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    db_reg  <= db_next;
                end
            end

            assign db_next_vec[gi] = db_next;

            if (gi == 0) begin : g_a
`ifdef BTN_LONGPRESS_EN
                assign a_db          = db_reg;
                assign a_db_next     = db_next;
                assign pulse_vec[gi] = a_pulse_reg;
`else
                logic db_prev_reg;
                logic pulse_reg;

                // Strobe on the cycle after the debounced level rises
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        db_prev_reg <= 1'b0;
                        pulse_reg   <= 1'b0;
                    end else begin
                        db_prev_reg <= db_reg;
                        pulse_reg   <= db_reg & ~db_prev_reg;
                    end
                end

                assign pulse_vec[gi] = pulse_reg;
`endif
            end else begin : g_bc
                logic db_prev_reg;
                logic pulse_reg;

                // Strobe on the cycle after the debounced level rises
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        db_prev_reg <= 1'b0;
                        pulse_reg   <= 1'b0;
                    end else begin
                        db_prev_reg <= db_reg;
                        pulse_reg   <= db_reg & ~db_prev_reg;
                    end
                end

                assign pulse_vec[gi] = pulse_reg;
            end
        end
    endgenerate

`ifdef BTN_LONGPRESS_EN
    assign hold_inc = (hold_reg == LONG_MAX) ? hold_reg : hold_reg + 1'b1;

    // Channel A press classifier. The rise is taken from the next-level so
    // the hold count starts on the same edge the debounced level goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state_reg <= IDLE;
            hold_reg    <= '0;
            a_pulse_reg <= 1'b0;
            test_reg    <= 1'b0;
        end else begin
            a_pulse_reg <= 1'b0;
            case (a_state_reg)
                IDLE: begin
                    if (a_db_next && !a_db) begin
                        a_state_reg <= DOWN;
                        hold_reg    <= '0;
                    end
                end
                DOWN: begin
                    if (!a_db) begin
                        // Released before the long threshold: short press
                        a_state_reg <= IDLE;
                        a_pulse_reg <= 1'b1;
                    end else if (hold_inc == LONG_MAX) begin
                        a_state_reg <= LONG;
                        hold_reg    <= hold_inc;
                        test_reg    <= ~test_reg;
                    end else begin
                        hold_reg <= hold_inc;
                    end
                end
                LONG: begin
                    if (!a_db) begin
                        a_state_reg <= IDLE;
                    end
                end
                default: a_state_reg <= IDLE;
            endcase
        end
    end

    assign test = test_reg;
`else
    assign test = 1'b0;
`endif

    // any_pressed follows the debounced levels on the same edge they change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_pressed_reg <= 1'b0;
        end else begin
            any_pressed_reg <= |db_next_vec;
        end
    end

    assign a_pulse     = pulse_vec[0];
    assign b_pulse     = pulse_vec[1];
    assign c_pulse     = pulse_vec[2];
    assign any_pressed = any_pressed_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYC=4, LONG_CYC=20.
// Adapts its expectations to whether BTN_LONGPRESS_EN is defined.
module tb_button_conditioner;
    localparam int DEB  = 4;
    localparam int LONG = 20;
`ifdef BTN_LONGPRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic btn_a = 1'b0;
    logic btn_b = 1'b0;
    logic btn_c = 1'b0;
    logic a_pulse, b_pulse, c_pulse, test, any_pressed;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_a      (btn_a),
        .btn_b      (btn_b),
        .btn_c      (btn_c),
        .a_pulse    (a_pulse),
        .b_pulse    (b_pulse),
        .c_pulse    (c_pulse),
        .test       (test),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    // Reference model state: history of effective raw samples, debounced
    // levels after the current/previous edges, press timestamps for A.
    logic [2:0] hist[$];
    logic [2:0] db_m = 3'b000;
    logic [2:0] d1_m = 3'b000;
    logic [2:0] d2_m = 3'b000;
    int         since_rel = 0;
    int         n_edge = 0;
    bit         test_m = 1'b0;
    logic [4:0] exp_v = 5'b0;
`ifdef BTN_LONGPRESS_EN
    int         rise_a = 0;
    bit         in_press = 1'b0;
    bit         pend_a = 1'b0;
`endif

    typedef struct {
        logic [2:0] mask;
        int hold;
        int a_cnt;
        int a_first;
        int b_cnt;
        int b_first;
        int c_cnt;
        int c_first;
        int any_cyc;
        int test_end;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [4:0] outs();
        return {a_pulse, b_pulse, c_pulse, test, any_pressed};
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Advance the model by one rising edge using the button levels at that edge
    task automatic model_step();
        logic [2:0] eff;
        logic [2:0] pulses;
        bit         a_now;
        int         s;
        bit         flip;
        n_edge++;
        if (!rst) begin
            since_rel = 0;
            db_m = 3'b000;
            d1_m = 3'b000;
            d2_m = 3'b000;
            hist.delete();
            test_m = 1'b0;
`ifdef BTN_LONGPRESS_EN
            in_press = 1'b0;
            pend_a = 1'b0;
`endif
            exp_v = 5'b0;
            return;
        end
        since_rel++;
        // The design's internal reset releases two edges after rst rises,
        // so the synchronizer first captures the button on the third edge.
        eff = (since_rel >= 3) ? {btn_c, btn_b, btn_a} : 3'b000;
        hist.push_back(eff);
        if (hist.size() > 8) void'(hist.pop_front());
        d2_m = d1_m;
        d1_m = db_m;
        // Level flips when the four samples seen 2..5 edges ago all disagree
        s = hist.size();
        if (s >= 6) begin
            for (int ch = 0; ch < 3; ch++) begin
                flip = 1'b1;
                for (int j = 2; j <= 5; j++) begin
                    if (hist[s-1-j][ch] == db_m[ch]) flip = 1'b0;
                end
                if (flip) db_m[ch] = ~db_m[ch];
            end
        end
        pulses = d1_m & ~d2_m;
`ifdef BTN_LONGPRESS_EN
        a_now  = pend_a;
        pend_a = 1'b0;
        if (in_press && (n_edge - rise_a == LONG)) test_m = ~test_m;
        if (db_m[0] && !d1_m[0]) begin
            in_press = 1'b1;
            rise_a   = n_edge;
        end else if (!db_m[0] && d1_m[0]) begin
            if (in_press && (n_edge - rise_a < LONG)) pend_a = 1'b1;
            in_press = 1'b0;
        end
`else
        a_now = pulses[0];
`endif
        exp_v = {a_now, pulses[1], pulses[2], test_m, |db_m};
    endtask

    task automatic tick();
        logic [4:0] got;
        @(posedge clk);
        model_step();
        #1;
        got = outs();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL cycle %0d outputs{a,b,c,test,any}: got %b expected %b",
                     n_edge, got, exp_v);
        end
    endtask

    task automatic run_row(input int idx, input vec_t r);
        int ac, af, bc, bf, cc, cf, anyc;
        ac = 0; af = 0; bc = 0; bf = 0; cc = 0; cf = 0; anyc = 0;
        {btn_c, btn_b, btn_a} = r.mask;
        for (int t = 1; t <= r.hold + 30; t++) begin
            tick();
            if (a_pulse) begin ac++; if (af == 0) af = t; end
            if (b_pulse) begin bc++; if (bf == 0) bf = t; end
            if (c_pulse) begin cc++; if (cf == 0) cf = t; end
            if (any_pressed) anyc++;
            if (t == r.hold) {btn_c, btn_b, btn_a} = 3'b000;
        end
        $display("row %0d mask=%b hold=%0d: a=%0d@%0d b=%0d@%0d c=%0d@%0d any=%0d test=%0b",
                 idx, r.mask, r.hold, ac, af, bc, bf, cc, cf, anyc, test);
        check($sformatf("row%0d a_pulse count", idx), ac, r.a_cnt);
        check($sformatf("row%0d a_pulse cycle", idx), af, r.a_first);
        check($sformatf("row%0d b_pulse count", idx), bc, r.b_cnt);
        check($sformatf("row%0d b_pulse cycle", idx), bf, r.b_first);
        check($sformatf("row%0d c_pulse count", idx), cc, r.c_cnt);
        check($sformatf("row%0d c_pulse cycle", idx), cf, r.c_first);
        check($sformatf("row%0d any_pressed cycles", idx), anyc, r.any_cyc);
        check($sformatf("row%0d test level", idx), int'(test), r.test_end);
    endtask

    initial begin
        logic pat[8];
        int   cnt_c, cnt_any, ac, any_first;
        int   lvl[3], remain[3], rst_hold;

        // mask, hold, a_cnt, a_first, b_cnt, b_first, c_cnt, c_first, any, test_end
        tbl[0]  = '{3'b010, 10, 0, 0, 1, 7, 0, 0, 10, 0};
        tbl[1]  = '{3'b010,  3, 0, 0, 0, 0, 0, 0,  0, 0};
        tbl[2]  = '{3'b010,  4, 0, 0, 1, 7, 0, 0,  4, 0};
        tbl[3]  = '{3'b001,  8, 1, LP ? 15 : 7, 0, 0, 0, 0,  8, 0};
        tbl[4]  = '{3'b001, 19, 1, LP ? 26 : 7, 0, 0, 0, 0, 19, 0};
        tbl[5]  = '{3'b001, 20, LP ? 0 : 1, LP ? 0 : 7, 0, 0, 0, 0, 20, LP ? 1 : 0};
        tbl[6]  = '{3'b001, 40, LP ? 0 : 1, LP ? 0 : 7, 0, 0, 0, 0, 40, 0};
        tbl[7]  = '{3'b001, 40, LP ? 0 : 1, LP ? 0 : 7, 0, 0, 0, 0, 40, LP ? 1 : 0};
        tbl[8]  = '{3'b001, 40, LP ? 0 : 1, LP ? 0 : 7, 0, 0, 0, 0, 40, 0};
        tbl[9]  = '{3'b011, 10, 1, LP ? 17 : 7, 1, 7, 0, 0, 10, 0};
        tbl[10] = '{3'b111,  6, 1, LP ? 13 : 7, 1, 7, 1, 7,  6, 0};
        tbl[11] = '{3'b100,  5, 0, 0, 0, 0, 1, 7,  5, 0};

        // Power-on reset
        rst = 1'b0;
        repeat (3) tick();
        check("reset state", int'(outs()), 0);
        rst = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 12; i++) run_row(i, tbl[i]);

        // C bounces with 2-cycle periods: never accepted
        pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b0;
        pat[4] = 1'b1; pat[5] = 1'b1; pat[6] = 1'b0; pat[7] = 1'b0;
        cnt_c = 0; cnt_any = 0;
        for (int t = 0; t < 28; t++) begin
            btn_c = (t < 8) ? pat[t] : 1'b0;
            tick();
            if (c_pulse) cnt_c++;
            if (any_pressed) cnt_any++;
        end
        $display("bounce C: c_pulse=%0d any=%0d", cnt_c, cnt_any);
        check("bounce c_pulse count", cnt_c, 0);
        check("bounce any_pressed cycles", cnt_any, 0);

        // Reset during a long hold on A, button still held through release
        btn_a = 1'b1;
        for (int t = 1; t <= 30; t++) tick();
        check("test before reset", int'(test), int'(LP));
        rst = 1'b0;
        #1;
        check("async reset clears outputs", int'(outs()), 0);
        repeat (3) tick();
        rst = 1'b1;
        ac = 0; any_first = 0;
        for (int t = 1; t <= 50; t++) begin
            tick();
            if (a_pulse) ac++;
            if (any_pressed && any_first == 0) any_first = t;
            if (t == 20) btn_a = 1'b0;
        end
        $display("held across reset: a_pulse=%0d any_first=%0d test=%0b", ac, any_first, test);
        check("post-reset a_pulse count", ac, 1);
        check("post-reset any_pressed first cycle", any_first, 8);
        check("post-reset test level", int'(test), 0);

        // Random stimulus against the reference model, with occasional resets
        for (int ch = 0; ch < 3; ch++) begin lvl[ch] = 0; remain[ch] = 0; end
        rst_hold = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (remain[ch] == 0) begin
                    lvl[ch] = int'($urandom_range(0, 1));
                    remain[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                                             : int'($urandom_range(1, 6));
                end
                remain[ch]--;
            end
            btn_a = lvl[0][0];
            btn_b = lvl[1][0];
            btn_c = lvl[2][0];
            if (rst && $urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                #1;
                check("random async reset clears outputs", int'(outs()), 0);
                rst_hold = int'($urandom_range(0, 2));
            end else if (!rst) begin
                if (rst_hold == 0) rst = 1'b1;
                else rst_hold--;
            end
            tick();
        end
        rst = 1'b1;
        {btn_c, btn_b, btn_a} = 3'b000;
        repeat (60) tick();
        check("idle after random any_pressed", int'(any_pressed), 0);
        $display("random phase done at edge %0d", n_edge);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 500000 (10 ms at 50 MHz), the number of consecutive stable cycles needed to accept a level change.
REQ-002 Parameter LONG_CYC, default 100000000 (2 s at 50 MHz), the debounced hold time on A that counts as a long press.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btn_a, btn_b, btn_c  input  1 each  raw, asynchronous, active-high pushbuttons.
REQ-006 a_pulse, b_pulse, c_pulse  output  1 each  one-cycle action strobes that feed the pet FSM inputs A, B and C.
REQ-007 test  output  1  level that selects the pet FSM test mode (accelerated timers).
REQ-008 any_pressed  output  1  high while any debounced button level is high.

Function
REQ-009 Each raw input shall pass through a 2-flop synchronizer before any other logic sees it.
REQ-010 Each channel shall have its own debounce counter: clear on any synchronized sample that equals the current debounced level; otherwise increment.
REQ-011 When a counter reaches DEBOUNCE_CYC, the debounced level shall flip and the counter shall clear.
REQ-012 A bounce shorter than DEBOUNCE_CYC cycles shall change nothing.
REQ-013 For a clean edge, the debounced level shall change exactly DEBOUNCE_CYC+2 cycles after the raw edge.
REQ-014 b_pulse and c_pulse shall be high for exactly one cycle, in the cycle after the debounced level rises; releasing the button produces no pulse.
REQ-015 Channel A shall run an FSM with states IDLE, DOWN, LONG.
REQ-016 IDLE -> DOWN when debounced A rises; the hold counter clears on entry.
REQ-017 In DOWN, the hold counter increments each cycle, saturating at LONG_CYC.
REQ-018 DOWN -> IDLE on debounced A falling before the hold counter reaches LONG_CYC, with a_pulse high for one cycle (pulse on release).
REQ-019 DOWN -> LONG when the hold counter reaches LONG_CYC: test toggles in that cycle and no a_pulse is ever emitted for that press.
REQ-020 LONG -> IDLE on debounced A falling, with no pulse.
REQ-021 Channels shall be independent: simultaneous presses shall give pulses in the same cycle, with no priority and no masking.
REQ-022 any_pressed = OR of the three debounced levels, registered, with no extra latency beyond the debounce.

Reset
REQ-023 rst low shall asynchronously clear synchronizers, counters, debounced levels, FSM (IDLE), all pulses, test and any_pressed to 0.
REQ-024 Release of rst shall be synchronized internally, with outputs changing no earlier than 2 cycles after rst rises.
REQ-025 A button held across reset release shall be treated as a new press after DEBOUNCE_CYC+2 cycles.
REQ-026 Reset asserted mid-press, mid-debounce or in LONG shall discard the press with no pulse and shall leave test at 0.

Configuration
REQ-027 Macro BTN_LONGPRESS_EN defined: channel A shall behave per REQ-015..REQ-020.
REQ-028 Macro BTN_LONGPRESS_EN undefined: the channel-A FSM and hold counter shall be removed.
REQ-029 Macro BTN_LONGPRESS_EN undefined: a_pulse shall behave like b_pulse (pulse on debounced press).
REQ-030 Macro BTN_LONGPRESS_EN undefined: test shall be constant 0.

Verification (DEBOUNCE_CYC=4, LONG_CYC=20, BTN_LONGPRESS_EN defined unless noted)
REQ-031 B clean press held 10 cycles -> b_pulse high exactly 1 cycle, 7 cycles after the raw edge; no pulse on release; any_pressed high for 10 cycles.
REQ-032 C toggling 1,0,1,0 with 2-cycle periods, then low -> no c_pulse; any_pressed stays 0.
REQ-033 A held 8 cycles -> no pulse during the hold; a_pulse 1 cycle, one cycle after the debounced fall; test stays 0.
REQ-034 A held 40 cycles -> test 0->1 exactly 20 cycles after the debounced rise; no a_pulse; second identical hold -> test returns to 0.
REQ-035 A and B pressed in the same cycle, 10 cycles -> b_pulse at cycle 7; a_pulse only after the A release; rst pulled low during a 40-cycle A hold at cycle 15 -> all outputs 0 immediately, test remains 0.
REQ-036 BTN_LONGPRESS_EN undefined, A held 40 cycles -> a_pulse 1 cycle at cycle 7; test constant 0.
